// File: rtl/music_pkg.sv
// music_pkg: note codes, frequency table and FSM encoding shared by the music path
package music_pkg;
  localparam int NOTE_W = 5;
  localparam logic [NOTE_W-1:0] S  = 5'd0;
  localparam logic [NOTE_W-1:0] C4 = 5'd1;
  localparam logic [NOTE_W-1:0] D4 = 5'd2;
  localparam logic [NOTE_W-1:0] E4 = 5'd3;
  localparam logic [NOTE_W-1:0] F4 = 5'd4;
  localparam logic [NOTE_W-1:0] G4 = 5'd5;
  localparam logic [NOTE_W-1:0] A4 = 5'd6;
  localparam logic [NOTE_W-1:0] B4 = 5'd7;
  localparam logic [NOTE_W-1:0] C5 = 5'd8;
  localparam logic [NOTE_W-1:0] D5 = 5'd9;
  localparam logic [NOTE_W-1:0] E5 = 5'd10;
  localparam logic [NOTE_W-1:0] F5 = 5'd11;
  localparam logic [NOTE_W-1:0] G5 = 5'd12;
  localparam logic [NOTE_W-1:0] A5 = 5'd13;
  localparam logic [NOTE_W-1:0] B5 = 5'd14;
  localparam logic [NOTE_W-1:0] C6 = 5'd15;
  localparam int unsigned FREQ_TBL [1:15] = '{262, 294, 330, 349, 392, 440, 494, 523,
                                             587, 659, 698, 784, 880, 988, 1047};
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;
endpackage

// File: rtl/music_tone_gen_if.sv
// music_tone_gen_if: note request in, square-wave tone and status out
interface music_tone_gen_if;
  import music_pkg::*;
  logic [NOTE_W-1:0] note;
  logic enable;
  logic audio_out;
  logic busy;
  logic period_done;
  modport master (output note, enable, input audio_out, busy, period_done);
  modport slave (input note, enable, output audio_out, busy, period_done);
endinterface

// File: rtl/music_note_lut.sv
// music_note_lut: note code to half-period cycle count, zero for silence and unused codes
module music_note_lut
  import music_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 22
) (
  input  logic [NOTE_W-1:0] i_note,
  output logic [CNT_W-1:0]  o_half
);
  logic [CNT_W-1:0] w_tbl [16];
  assign w_tbl[0] = '0;
  for (genvar i = 1; i < 16; i++) begin : g_tbl
    assign w_tbl[i] = CNT_W'(CLK_HZ / (2 * FREQ_TBL[i]));
  end
  // codes with the top bit set are outside the table and play as silence
  always_comb o_half = i_note[NOTE_W-1] ? '0 : w_tbl[i_note[NOTE_W-2:0]];
endmodule

// File: rtl/music_tone_gen.sv
// music_tone_gen: glitch-free square-wave tone generator switching notes only at period ends
module music_tone_gen
  import music_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 22
) (
  input logic clk,
  input logic rst,
  music_tone_gen_if.slave bus
);
  state_t            r_state, w_state_nx;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nx, w_half;
  logic              r_audio, w_audio_nx;
  logic              r_done, w_done_nx;
  logic [NOTE_W-1:0] r_cur_note, w_cur_nx, w_lut_note;
  logic w_play_ok, w_end, w_fall, w_fin, w_samp, w_load;
  // end of the high half reloads from the latched note, every other load from the input
  assign w_lut_note = w_fall ? r_cur_note : bus.note;
  music_note_lut #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) u_lut (
    .i_note (w_lut_note),
    .o_half (w_half)
  );
  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_audio    <= 1'b0;
      r_done     <= 1'b0;
      r_cur_note <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_audio    <= w_audio_nx;
      r_done     <= w_done_nx;
      r_cur_note <= w_cur_nx;
    end
  end
  // inputs are only looked at in IDLE or at the last low cycle of a period
  always_comb begin
    w_play_ok  = bus.enable && bus.note != '0 && !bus.note[NOTE_W-1];
    w_end      = r_cnt == '0;
    w_fall     = r_state == PLAY && w_end && r_audio;
    w_fin      = r_state == PLAY && w_end && !r_audio;
    w_samp     = r_state == IDLE || w_fin;
    w_load     = w_samp && w_play_ok;
    w_state_nx = w_samp ? (w_play_ok ? PLAY : IDLE) : r_state;
    w_cnt_nx   = (w_load || w_fall) ? w_half - CNT_W'(1) :
                 (r_state == PLAY && !w_end) ? r_cnt - CNT_W'(1) : r_cnt;
    w_audio_nx = w_load ? 1'b1 : w_fall ? 1'b0 : r_audio;
    w_cur_nx   = w_load ? bus.note : r_cur_note;
    w_done_nx  = w_fin;
  end
  // outputs straight from registers so the pin never glitches
  always_comb begin
    bus.busy        = r_state == PLAY;
    bus.audio_out   = r_audio;
    bus.period_done = r_done;
  end
endmodule
